// File: rtl/bsg_mem_sched_pkg.sv
// Shared types for the 2r1w read scheduler: grant record and round-robin wrap helper.
package bsg_mem_sched_pkg;

   // Wide enough for the largest supported requester count (16).
   localparam int max_id_width_gp = 4;

   typedef struct packed {
      logic                       v;
      logic [max_id_width_gp-1:0] id;
   } grant_s;

   function automatic logic [max_id_width_gp-1:0] wrap_inc
     (input logic [max_id_width_gp-1:0] id, input int unsigned n);
      if (int'(id) >= int'(n) - 1)
         return '0;
      return id + 1'b1;
   endfunction

endpackage

// File: rtl/bsg_mem_2r1w_sync_sched_if.sv
// Requester-side read bus of the 2r1w scheduler: requests in, yumi and responses out.
interface bsg_mem_2r1w_sync_sched_if #(
   parameter int width_p      = 32,
   parameter int addr_width_p = 5,
   parameter int num_req_p    = 4
);
   logic [num_req_p-1:0]                   req_v_i;
   logic [num_req_p-1:0][addr_width_p-1:0] req_addr_i;
   logic [num_req_p-1:0]                   req_yumi_o;
   logic [num_req_p-1:0]                   resp_v_o;
   logic [num_req_p-1:0][width_p-1:0]      resp_data_o;

   modport master (output req_v_i, req_addr_i,
                   input  req_yumi_o, resp_v_o, resp_data_o);
   modport slave  (input  req_v_i, req_addr_i,
                   output req_yumi_o, resp_v_o, resp_data_o);
endinterface

// File: rtl/bsg_arb_rr_pick2.sv
// Combinational round-robin picker: first two eligible requesters starting at ptr_i.
module bsg_arb_rr_pick2
   import bsg_mem_sched_pkg::*;
#(
   parameter int num_req_p = 4
)(
   input  logic [num_req_p-1:0]       elig_i,
   input  logic [max_id_width_gp-1:0] ptr_i,
   output grant_s                     grant0_o,
   output grant_s                     grant1_o
);

   always_comb begin
      int     idx;
      grant_s g0, g1;
      g0  = '0;
      g1  = '0;
      idx = 0;
      for (int i = 0; i < num_req_p; i++) begin
         idx = int'(ptr_i) + i;
         if (idx >= num_req_p)
            idx = idx - num_req_p;
         if (elig_i[idx]) begin
            if (!g0.v) begin
               g0.v  = 1'b1;
               g0.id = max_id_width_gp'(idx);
            end else if (!g1.v) begin
               g1.v  = 1'b1;
               g1.id = max_id_width_gp'(idx);
            end
         end
      end
      grant0_o = g0;
      grant1_o = g1;
   end

endmodule

// File: rtl/bsg_mem_2r1w_sync_sched.sv
// Read scheduler / write-port owner for one 2r1w sync memory (no read-same-addr-as-write).
// Optional BSG_MEM_SCHED_WRITE_BYPASS_EN: conflicting reads are served from the write data.
module bsg_mem_2r1w_sync_sched
   import bsg_mem_sched_pkg::*;
#(
   parameter int width_p   = 32,
   parameter int els_p     = 32,
   parameter int num_req_p = 4,
   localparam int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1,
   localparam int id_width_lp   = (num_req_p > 1) ? $clog2(num_req_p) : 1
)(
   input  logic                     clk_i,
   input  logic                     reset_n_i,
   bsg_mem_2r1w_sync_sched_if.slave rd_if,
   input  logic                     w_v_i,
   input  logic [addr_width_lp-1:0] w_addr_i,
   input  logic [width_p-1:0]       w_data_i,
   output logic                     mem_w_v_o,
   output logic [addr_width_lp-1:0] mem_w_addr_o,
   output logic [width_p-1:0]       mem_w_data_o,
   output logic                     mem_r0_v_o,
   output logic [addr_width_lp-1:0] mem_r0_addr_o,
   output logic                     mem_r1_v_o,
   output logic [addr_width_lp-1:0] mem_r1_addr_o,
   input  logic [width_p-1:0]       mem_r0_data_i,
   input  logic [width_p-1:0]       mem_r1_data_i
);

   logic [num_req_p-1:0]       hit, elig;
   logic [max_id_width_gp-1:0] rr_ptr, rr_ptr_n;
   grant_s                     g0, g1, r0_q, r1_q;
   logic                       byp0, byp1;

   assign mem_w_v_o    = w_v_i & reset_n_i;
   assign mem_w_addr_o = w_addr_i;
   assign mem_w_data_o = w_data_i;

   always_comb begin
      hit = '0;
      for (int k = 0; k < num_req_p; k++)
         hit[k] = w_v_i && (rd_if.req_addr_i[k] == w_addr_i);
   end

   // Gating with reset keeps every grant, strobe and yumi low while in reset.
`ifdef BSG_MEM_SCHED_WRITE_BYPASS_EN
   assign elig = rd_if.req_v_i & {num_req_p{reset_n_i}};
`else
   assign elig = rd_if.req_v_i & ~hit & {num_req_p{reset_n_i}};
`endif

   bsg_arb_rr_pick2 #(.num_req_p(num_req_p)) u_pick (
      .elig_i   (elig),
      .ptr_i    (rr_ptr),
      .grant0_o (g0),
      .grant1_o (g1)
   );

   // Decode grants by comparison so ids never index narrower vectors.
   always_comb begin
      rd_if.req_yumi_o = '0;
      mem_r0_addr_o    = '0;
      mem_r1_addr_o    = '0;
      byp0             = 1'b0;
      byp1             = 1'b0;
      for (int k = 0; k < num_req_p; k++) begin
         if (g0.v && g0.id == max_id_width_gp'(k)) begin
            rd_if.req_yumi_o[k] = 1'b1;
            mem_r0_addr_o       = rd_if.req_addr_i[k];
            byp0                = hit[k];
         end
         if (g1.v && g1.id == max_id_width_gp'(k)) begin
            rd_if.req_yumi_o[k] = 1'b1;
            mem_r1_addr_o       = rd_if.req_addr_i[k];
            byp1                = hit[k];
         end
      end
   end

`ifdef BSG_MEM_SCHED_WRITE_BYPASS_EN
   assign mem_r0_v_o = g0.v & ~byp0;
   assign mem_r1_v_o = g1.v & ~byp1;
`else
   // Conflicting requesters are never eligible, so hit is irrelevant here.
   assign mem_r0_v_o = g0.v;
   assign mem_r1_v_o = g1.v;
   logic unused_byp;
   assign unused_byp = byp0 | byp1;
`endif

   always_comb begin
      rr_ptr_n = rr_ptr;
      if (g1.v)
         rr_ptr_n = wrap_inc(g1.id, num_req_p);
      else if (g0.v)
         rr_ptr_n = wrap_inc(g0.id, num_req_p);
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         rr_ptr <= '0;
         r0_q   <= '0;
         r1_q   <= '0;
      end else begin
         rr_ptr <= rr_ptr_n;
         r0_q   <= g0;
         r1_q   <= g1;
      end
   end

`ifdef BSG_MEM_SCHED_WRITE_BYPASS_EN
   logic               r0_byp_q, r1_byp_q;
   logic [width_p-1:0] w_data_q;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r0_byp_q <= 1'b0;
         r1_byp_q <= 1'b0;
         w_data_q <= '0;
      end else begin
         r0_byp_q <= g0.v & byp0;
         r1_byp_q <= g1.v & byp1;
         w_data_q <= w_data_i;
      end
   end

   wire [width_p-1:0] r0_data = r0_byp_q ? w_data_q : mem_r0_data_i;
   wire [width_p-1:0] r1_data = r1_byp_q ? w_data_q : mem_r1_data_i;
`else
   wire [width_p-1:0] r0_data = mem_r0_data_i;
   wire [width_p-1:0] r1_data = mem_r1_data_i;
`endif

   always_comb begin
      rd_if.resp_v_o    = '0;
      rd_if.resp_data_o = '0;
      for (int k = 0; k < num_req_p; k++) begin
         if (r0_q.v && r0_q.id == max_id_width_gp'(k)) begin
            rd_if.resp_v_o[k]    = 1'b1;
            rd_if.resp_data_o[k] = r0_data;
         end
         if (r1_q.v && r1_q.id == max_id_width_gp'(k)) begin
            rd_if.resp_v_o[k]    = 1'b1;
            rd_if.resp_data_o[k] = r1_data;
         end
      end
   end

`ifndef SYNTHESIS
   // Only meaningful when els_p leaves unused address codes.
   if (els_p < (1 << addr_width_lp)) begin : g_range_chk
      always_ff @(posedge clk_i) begin
         if (reset_n_i) begin
            if (w_v_i)
               assert (w_addr_i < addr_width_lp'(els_p))
                  else $error("write address out of range");
            for (int k = 0; k < num_req_p; k++)
               if (rd_if.req_v_i[k])
                  assert (rd_if.req_addr_i[k] < addr_width_lp'(els_p))
                     else $error("read address out of range");
         end
      end
   end
`endif

endmodule

// File: tb/tb_bsg_mem_2r1w_sync_sched.sv
// Directed table-driven bench for bsg_mem_2r1w_sync_sched with a behavioural 2r1w memory.
module tb_bsg_mem_2r1w_sync_sched;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        w_v;
   logic [4:0]  w_addr;
   logic [31:0] w_data;
   logic        mem_w_v, mem_r0_v, mem_r1_v;
   logic [4:0]  mem_w_addr, mem_r0_addr, mem_r1_addr;
   logic [31:0] mem_w_data, mem_r0_data, mem_r1_data;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   bsg_mem_2r1w_sync_sched_if #(.width_p(32), .addr_width_p(5), .num_req_p(4)) rif ();

   bsg_mem_2r1w_sync_sched #(.width_p(32), .els_p(32), .num_req_p(4)) dut (
      .clk_i         (clk),
      .reset_n_i     (reset_n),
      .rd_if         (rif.slave),
      .w_v_i         (w_v),
      .w_addr_i      (w_addr),
      .w_data_i      (w_data),
      .mem_w_v_o     (mem_w_v),
      .mem_w_addr_o  (mem_w_addr),
      .mem_w_data_o  (mem_w_data),
      .mem_r0_v_o    (mem_r0_v),
      .mem_r0_addr_o (mem_r0_addr),
      .mem_r1_v_o    (mem_r1_v),
      .mem_r1_addr_o (mem_r1_addr),
      .mem_r0_data_i (mem_r0_data),
      .mem_r1_data_i (mem_r1_data)
   );

   // Memory model: unwritten location a holds 0xA0 + a.
   logic [31:0] mem [32];
   bit   [31:0] mem_wr;

   function automatic logic [31:0] rd(input logic [4:0] a);
      return mem_wr[a] ? mem[a] : 32'hA0 + 32'(a);
   endfunction

   always @(posedge clk) begin
      if (mem_w_v) begin
         mem[mem_w_addr]    <= mem_w_data;
         mem_wr[mem_w_addr] <= 1'b1;
      end
      if (mem_r0_v) mem_r0_data <= rd(mem_r0_addr);
      if (mem_r1_v) mem_r1_data <= rd(mem_r1_addr);
   end

   typedef struct {
      logic [3:0]       req_v;
      logic [3:0][4:0]  addr;
      logic             w_v;
      logic [4:0]       w_addr;
      logic [31:0]      w_data;
      logic [3:0]       yumi;
      logic             r0_v;
      logic             r1_v;
      logic [3:0]       resp_v;
      logic [3:0][31:0] resp_data;
   } vec_t;

   vec_t vt[$];

   function automatic vec_t row(logic [3:0] rv, logic [19:0] ad, logic wv, logic [4:0] wa,
                                logic [31:0] wd, logic [3:0] y, logic r0, logic r1,
                                logic [3:0] sv, logic [127:0] sd);
      vec_t v;
      v.req_v = rv; v.addr = ad; v.w_v = wv; v.w_addr = wa; v.w_data = wd;
      v.yumi = y; v.r0_v = r0; v.r1_v = r1; v.resp_v = sv; v.resp_data = sd;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic [3:0] rv, input logic [19:0] ad, input logic wv,
                        input logic [4:0] wa, input logic [31:0] wd);
      rif.req_v_i    = rv;
      rif.req_addr_i = ad;
      w_v            = wv;
      w_addr         = wa;
      w_data         = wd;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   localparam logic [19:0]  NA = 20'd0;
   localparam logic [127:0] ND = 128'd0;

   initial begin
      reset_n = 1'b0;
      drive(4'b1111, {5'd3, 5'd2, 5'd1, 5'd0}, 1'b1, 5'd4, 32'h5);

      // rows: req_v, addrs(3..0), w_v, w_addr, w_data, yumi, r0_v, r1_v, resp_v, resp_data(3..0)
      vt.push_back(row(4'b1111, {5'd13, 5'd12, 5'd11, 5'd10}, 1'b0, 5'd0, 32'd0, 4'b0011, 1'b1, 1'b1, 4'b0000, ND));
      vt.push_back(row(4'b1111, {5'd13, 5'd12, 5'd11, 5'd10}, 1'b0, 5'd0, 32'd0, 4'b1100, 1'b1, 1'b1, 4'b0011,
                       {32'h0, 32'h0, 32'hAB, 32'hAA}));
      vt.push_back(row(4'b0000, NA, 1'b0, 5'd0, 32'd0, 4'b0000, 1'b0, 1'b0, 4'b1100,
                       {32'hAD, 32'hAC, 32'h0, 32'h0}));
      vt.push_back(row(4'b0100, {5'd0, 5'd5, 5'd0, 5'd0}, 1'b0, 5'd0, 32'd0, 4'b0100, 1'b1, 1'b0, 4'b0000, ND));
      vt.push_back(row(4'b0000, NA, 1'b0, 5'd0, 32'd0, 4'b0000, 1'b0, 1'b0, 4'b0100,
                       {32'h0, 32'hA5, 32'h0, 32'h0}));
`ifdef BSG_MEM_SCHED_WRITE_BYPASS_EN
      vt.push_back(row(4'b0010, {5'd0, 5'd0, 5'd7, 5'd0}, 1'b1, 5'd7, 32'h11, 4'b0010, 1'b0, 1'b0, 4'b0000, ND));
      vt.push_back(row(4'b0000, NA, 1'b0, 5'd0, 32'd0, 4'b0000, 1'b0, 1'b0, 4'b0010,
                       {32'h0, 32'h0, 32'h11, 32'h0}));
      vt.push_back(row(4'b0000, NA, 1'b0, 5'd0, 32'd0, 4'b0000, 1'b0, 1'b0, 4'b0000, ND));
`else
      vt.push_back(row(4'b0010, {5'd0, 5'd0, 5'd7, 5'd0}, 1'b1, 5'd7, 32'h11, 4'b0000, 1'b0, 1'b0, 4'b0000, ND));
      vt.push_back(row(4'b0010, {5'd0, 5'd0, 5'd7, 5'd0}, 1'b0, 5'd0, 32'd0, 4'b0010, 1'b1, 1'b0, 4'b0000, ND));
      vt.push_back(row(4'b0000, NA, 1'b0, 5'd0, 32'd0, 4'b0000, 1'b0, 1'b0, 4'b0010,
                       {32'h0, 32'h0, 32'h11, 32'h0}));
`endif
      // Same address on two requesters; ptr is 2 here so 3 takes port 0, 0 takes port 1.
      vt.push_back(row(4'b1001, {5'd3, 5'd0, 5'd0, 5'd3}, 1'b0, 5'd0, 32'd0, 4'b1001, 1'b1, 1'b1, 4'b0000, ND));
      vt.push_back(row(4'b0000, NA, 1'b0, 5'd0, 32'd0, 4'b0000, 1'b0, 1'b0, 4'b1001,
                       {32'hA3, 32'h0, 32'h0, 32'hA3}));
`ifdef BSG_MEM_SCHED_WRITE_BYPASS_EN
      vt.push_back(row(4'b0011, {5'd0, 5'd0, 5'd9, 5'd4}, 1'b1, 5'd9, 32'h99, 4'b0011, 1'b0, 1'b1, 4'b0000, ND));
      vt.push_back(row(4'b0000, NA, 1'b0, 5'd0, 32'd0, 4'b0000, 1'b0, 1'b0, 4'b0011,
                       {32'h0, 32'h0, 32'h99, 32'hA4}));
      vt.push_back(row(4'b0000, NA, 1'b0, 5'd0, 32'd0, 4'b0000, 1'b0, 1'b0, 4'b0000, ND));
`else
      vt.push_back(row(4'b0011, {5'd0, 5'd0, 5'd9, 5'd4}, 1'b1, 5'd9, 32'h99, 4'b0001, 1'b1, 1'b0, 4'b0000, ND));
      vt.push_back(row(4'b0010, {5'd0, 5'd0, 5'd9, 5'd0}, 1'b0, 5'd0, 32'd0, 4'b0010, 1'b1, 1'b0, 4'b0001,
                       {32'h0, 32'h0, 32'h0, 32'hA4}));
      vt.push_back(row(4'b0000, NA, 1'b0, 5'd0, 32'd0, 4'b0000, 1'b0, 1'b0, 4'b0010,
                       {32'h0, 32'h0, 32'h99, 32'h0}));
`endif

      // In reset: requests and a write pending, everything must be held low.
      next_cycle();
      next_cycle();
      chk("rst_yumi",   128'(rif.req_yumi_o), 128'd0);
      chk("rst_w_v",    128'(mem_w_v), 128'd0);
      chk("rst_r_v",    128'({mem_r0_v, mem_r1_v}), 128'd0);
      chk("rst_resp_v", 128'(rif.resp_v_o), 128'd0);
      reset_n = 1'b1;

      foreach (vt[i]) begin
         drive(vt[i].req_v, vt[i].addr, vt[i].w_v, vt[i].w_addr, vt[i].w_data);
         @(negedge clk);
         chk($sformatf("yumi[%0d]", i), 128'(rif.req_yumi_o), 128'(vt[i].yumi));
         chk($sformatf("mem_w_v[%0d]", i), 128'(mem_w_v), 128'(vt[i].w_v));
         chk($sformatf("rd_v[%0d]", i), 128'({mem_r0_v, mem_r1_v}), 128'({vt[i].r0_v, vt[i].r1_v}));
         chk($sformatf("resp_v[%0d]", i), 128'(rif.resp_v_o), 128'(vt[i].resp_v));
         chk($sformatf("resp_data[%0d]", i), 128'(rif.resp_data_o), 128'(vt[i].resp_data));
         next_cycle();
      end

      // Reset mid-flight: grant requester 0, then assert reset while its response is due.
      drive(4'b0001, {5'd0, 5'd0, 5'd0, 5'd1}, 1'b0, 5'd0, 32'd0);
      @(negedge clk);
      chk("mf_yumi", 128'(rif.req_yumi_o), 128'b0001);
      next_cycle();
      drive(4'b0000, NA, 1'b0, 5'd0, 32'd0);
      chk("mf_resp_pre", 128'(rif.resp_v_o), 128'b0001);
      reset_n = 1'b0;
      #1;
      chk("mf_resp_rst", 128'(rif.resp_v_o), 128'd0);
      next_cycle();
      reset_n = 1'b1;
      @(negedge clk);
      chk("mf_resp_drop", 128'(rif.resp_v_o), 128'd0);
      next_cycle();
      drive(4'b1111, {5'd3, 5'd2, 5'd1, 5'd0}, 1'b0, 5'd0, 32'd0);
      @(negedge clk);
      chk("mf_first_grant", 128'(rif.req_yumi_o), 128'b0011);
      next_cycle();
      drive(4'b0000, NA, 1'b0, 5'd0, 32'd0);
      @(negedge clk);
      chk("mf_resp_v", 128'(rif.resp_v_o), 128'b0011);
      chk("mf_resp_data", 128'(rif.resp_data_o), {32'h0, 32'h0, 32'hA1, 32'hA0});
      next_cycle();

      // Idle for 10 cycles: no strobes, pointer (now 2) must hold.
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk($sformatf("idle_strobes[%0d]", c),
             128'({mem_w_v, mem_r0_v, mem_r1_v, rif.req_yumi_o, rif.resp_v_o}), 128'd0);
         next_cycle();
      end
      drive(4'b1111, {5'd3, 5'd2, 5'd1, 5'd0}, 1'b0, 5'd0, 32'd0);
      @(negedge clk);
      chk("idle_ptr_hold", 128'(rif.req_yumi_o), 128'b1100);
      next_cycle();
      drive(4'b0000, NA, 1'b0, 5'd0, 32'd0);
      @(negedge clk);
      chk("idle_resp_data", 128'(rif.resp_data_o), {32'hA3, 32'hA2, 32'h0, 32'h0});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
